// File: rtl/onehot_encoder_seq_pkg.sv
// Shared types for the sequential one-hot/multi-hot to binary-index encoder.
package onehot_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

endpackage

// File: rtl/onehot_encoder_seq_if.sv
// Request-vector input and index-beat output bundle for onehot_encoder_seq.
// Handshake: a transfer happens on a rising clk edge where valid && ready; a
// producer holds valid and its payload stable until that edge, and ready may
// be driven freely by the consumer without depending on valid.
interface onehot_encoder_seq_if #(
  parameter int N = 8,
  parameter int M = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/onehot_encoder_seq_ffs.sv
// Combinational find-first-set: lowest (or highest when msb_first) set bit of
// vec, plus found / exactly-one-bit-set flags.
module onehot_encoder_seq_ffs #(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         msb_first,
  output logic [M-1:0] idx,
  output logic         found,
  output logic         single
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // The last match in each loop wins, so the scan direction picks the end.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (msb_first) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          idx   = M'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = M'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign single = found && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/onehot_encoder_seq.sv
// Serialises a captured request vector into one binary index per output beat.
// Define ENC_MSB_FIRST_EN to emit the highest set bit first (default LSB first).
module onehot_encoder_seq
  import onehot_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int M = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_encoder_seq_if.slave  bus,
  output enc_state_t           dbg_state
);

`ifdef ENC_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  enc_state_t   state;
  logic [N-1:0] pend;
  logic [N-1:0] pend_clr;
  logic         zero;
  logic [M-1:0] ffs_idx;
  logic         ffs_found;
  logic         ffs_single;
  logic         last;

  onehot_encoder_seq_ffs #(.N(N), .M(M)) u_ffs (
    .vec       (pend),
    .msb_first (MSB_FIRST),
    .idx       (ffs_idx),
    .found     (ffs_found),
    .single    (ffs_single)
  );

  assign last = zero || ffs_single;

  always_comb begin
    pend_clr          = pend;
    pend_clr[ffs_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pend  <= bus.in_vec;
            zero  <= (bus.in_vec == '0);
            state <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (last) begin
              pend  <= '0;
              zero  <= 1'b0;
              state <= IDLE;
            end else begin
              pend <= pend_clr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the live handshake inputs.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_idx   = ffs_found ? ffs_idx : '0;
  assign bus.out_last  = (state == EMIT) && last;
  assign bus.out_none  = (state == EMIT) && zero;
  assign dbg_state     = state;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Directed bench for onehot_encoder_seq: a beat-list model plus literal checks.
module tb_onehot_encoder_seq;
  import onehot_enc_pkg::*;

  localparam int N = 8;
  localparam int M = $clog2(N);
  localparam int W = M + 2;

  logic       clk;
  logic       rst;
  enc_state_t dbg_state;
  bit         toggle_ready;

  int n_cmp;
  int n_err;
  int cyc;
  int acc_cyc;
  int last_cyc;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] log_q[$];
  logic [W-1:0] lit_q[$];

  onehot_encoder_seq_if #(.N(N)) bus ();

  onehot_encoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name, input logic [W-1:0] e[$]);
    check({name, "_count"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      check({name, "_beat"}, log_q[i], e[i]);
  endtask

  // Model: beats are the set bit positions in scan order, LAST on the final one;
  // an empty vector yields a single NONE beat.
  task automatic model_push(input logic [N-1:0] v);
    int idx_list[$];
    for (int i = 0; i < N; i++)
      if (v[i]) idx_list.push_back(i);
`ifdef ENC_MSB_FIRST_EN
    idx_list.reverse();
`endif
    if (idx_list.size() == 0) begin
      exp_q.push_back({1'b1, 1'b1, {M{1'b0}}});
    end else begin
      for (int k = 0; k < idx_list.size(); k++)
        exp_q.push_back({1'b0, (k == idx_list.size() - 1), M'(idx_list[k])});
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        check("rst_out_valid", bus.out_valid, 0);
      end else begin
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        check("in_ready", bus.in_ready, exp_q.size() == 0);
        if (bus.out_valid && exp_q.size() > 0) begin
          check("beat", {bus.out_none, bus.out_last, bus.out_idx}, exp_q[0]);
          if (bus.out_ready) begin
            log_q.push_back({bus.out_none, bus.out_last, bus.out_idx});
            void'(exp_q.pop_front());
            if (bus.out_last) last_cyc = cyc;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          model_push(bus.in_vec);
          acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) bus.out_ready = ~bus.out_ready;
      else bus.out_ready = 1'b1;
    end
  end

  task automatic send_vec(input logic [N-1:0] v, input bit hold_valid);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.out_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    acc_cyc = 0;
    last_cyc = 0;
    toggle_ready = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vec = '0;
    #12;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_idx", bus.out_idx, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_out_none", bus.out_none, 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // multi-hot vector
    log_q.delete();
    send_vec(8'b1010_0100, 1'b0);
    wait_idle();
`ifdef ENC_MSB_FIRST_EN
    lit_q = '{5'b0_0_111, 5'b0_0_101, 5'b0_1_010};
`else
    lit_q = '{5'b0_0_010, 5'b0_0_101, 5'b0_1_111};
`endif
    check_log("multi_hot", lit_q);

    // zero vector
    log_q.delete();
    send_vec(8'h00, 1'b0);
    wait_idle();
    lit_q = '{5'b1_1_000};
    check_log("zero_vec", lit_q);

    // all ones with a stalling consumer
    log_q.delete();
    toggle_ready = 1'b1;
    send_vec(8'hFF, 1'b0);
    wait_idle();
    toggle_ready = 1'b0;
    lit_q.delete();
    for (int i = 0; i < N; i++) begin
`ifdef ENC_MSB_FIRST_EN
      lit_q.push_back({1'b0, (i == N - 1), M'(N - 1 - i)});
`else
      lit_q.push_back({1'b0, (i == N - 1), M'(i)});
`endif
    end
    check_log("all_ones", lit_q);

    // only MSB set
    log_q.delete();
    send_vec(8'h80, 1'b0);
    wait_idle();
    lit_q = '{5'b0_1_111};
    check_log("msb_only", lit_q);

    // reset in the middle of a vector
    log_q.delete();
    send_vec(8'b0001_1000, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("postreset_in_ready", bus.in_ready, 1);
`ifdef ENC_MSB_FIRST_EN
    lit_q = '{5'b0_0_100};
`else
    lit_q = '{5'b0_0_011};
`endif
    check_log("mid_reset", lit_q);
    @(posedge clk);
    #1;

    // back-to-back with valid held high
    log_q.delete();
    send_vec(8'h81, 1'b1);
    bus.in_vec = 8'h10;
    send_vec(8'h10, 1'b0);
    check("b2b_gap", acc_cyc - last_cyc, 1);
    wait_idle();
`ifdef ENC_MSB_FIRST_EN
    lit_q = '{5'b0_0_111, 5'b0_1_000, 5'b0_1_100};
`else
    lit_q = '{5'b0_0_000, 5'b0_1_111, 5'b0_1_100};
`endif
    check_log("back_to_back", lit_q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
